// File: rtl/date_pkg.sv
// Package date_pkg: shared types and constants for the day-of-year calculator.
//   state_t        : controller states (IDLE, CHECK, ACCUM, DONE)
//   MONTH_JAN..DEC : month numbers as entered on the front panel (1-based)
//   DAYS_IN_YEAR   : length of a common year
//   LEN_*          : month lengths returned by month_length_rom
//   BCD_MAX        : largest legal BCD digit
package date_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MONTH_JAN = 4'd1;
  localparam logic [3:0] MONTH_FEB = 4'd2;
  localparam logic [3:0] MONTH_MAR = 4'd3;
  localparam logic [3:0] MONTH_APR = 4'd4;
  localparam logic [3:0] MONTH_MAY = 4'd5;
  localparam logic [3:0] MONTH_JUN = 4'd6;
  localparam logic [3:0] MONTH_JUL = 4'd7;
  localparam logic [3:0] MONTH_AUG = 4'd8;
  localparam logic [3:0] MONTH_SEP = 4'd9;
  localparam logic [3:0] MONTH_OCT = 4'd10;
  localparam logic [3:0] MONTH_NOV = 4'd11;
  localparam logic [3:0] MONTH_DEC = 4'd12;

  localparam int DAYS_IN_YEAR = 365;

  localparam logic [4:0] LEN_31       = 5'd31;
  localparam logic [4:0] LEN_30       = 5'd30;
  localparam logic [4:0] LEN_FEB      = 5'd28;
  localparam logic [4:0] LEN_FEB_LEAP = 5'd29;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/day_of_year_calc_if.sv
// Interface day_of_year_calc_if: start/done handshake plus date operands and
// result of the day-of-year calculator.
//   master : date-entry front end (drives start, month, day digits, leap_year)
//   slave  : day_of_year_calc (drives busy, done, valid, day_of_year)
// Optional macro LEAP_YEAR_EN adds the leap_year signal.
interface day_of_year_calc_if #(
  parameter int DOY_W   = 9,
  parameter int MONTH_W = 4
);

  logic               start;
  logic [MONTH_W-1:0] month;
  logic [3:0]         day_tens;
  logic [3:0]         day_ones;
`ifdef LEAP_YEAR_EN
  logic               leap_year;
`endif
  logic               busy;
  logic               done;
  logic               valid;
  logic [DOY_W-1:0]   day_of_year;

  modport master (
    output start, month, day_tens, day_ones,
`ifdef LEAP_YEAR_EN
    output leap_year,
`endif
    input  busy, done, valid, day_of_year
  );

  modport slave (
    input  start, month, day_tens, day_ones,
`ifdef LEAP_YEAR_EN
    input  leap_year,
`endif
    output busy, done, valid, day_of_year
  );

endinterface

// File: rtl/month_length_rom.sv
// month_length_rom: combinational month-length lookup.
//   month : month number, 1 = January .. 12 = December
//   leap  : 1 = February has 29 days
//   len   : number of days in the month; 0 for an out-of-range month
module month_length_rom
  import date_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] len
);

  always_comb begin
    len = 5'd0;
    case (month)
      MONTH_JAN, MONTH_MAR, MONTH_MAY, MONTH_JUL,
      MONTH_AUG, MONTH_OCT, MONTH_DEC: len = LEN_31;
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: len = LEN_30;
      MONTH_FEB: len = leap ? LEN_FEB_LEAP : LEN_FEB;
      default:   len = 5'd0;
    endcase
  end

endmodule

// File: rtl/day_of_year_calc.sv
// day_of_year_calc: converts month + BCD two-digit day into day-of-year.
// Sequential: one month length is accumulated per clock.
//   clk, reset : system clock, synchronous active-high reset
//   bus.start  : request conversion (sampled only in IDLE)
//   bus.month, bus.day_tens, bus.day_ones : date operands (latched on start)
//   bus.leap_year : February has 29 days (only with LEAP_YEAR_EN defined)
//   bus.busy   : conversion in progress, including the DONE cycle
//   bus.done   : one-cycle pulse, result valid
//   bus.valid, bus.day_of_year : result, held until the next accepted start
// Optional macro LEAP_YEAR_EN enables leap-year support; without it February
// is fixed at 28 days.
module day_of_year_calc
  import date_pkg::*;
#(
  parameter int DOY_W   = 9,
  parameter int MONTH_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  day_of_year_calc_if.slave    bus
);

  state_t             state;
  state_t             state_nxt;

  logic [MONTH_W-1:0] month_q;
  logic [MONTH_W-1:0] idx_q;
  logic [6:0]         day_q;
  logic               digit_err_q;
  logic               leap_q;
  logic [DOY_W-1:0]   acc_q;
  logic [DOY_W-1:0]   doy_q;
  logic               valid_q;

  logic [MONTH_W-1:0] rom_month;
  logic [4:0]         len;
  logic               month_ok;
  logic               check_ok;
  logic [6:0]         day_in;

  // The day is only meaningful when both digits are legal BCD; any wrap in the
  // 7-bit sum for bad digits is irrelevant because digit_err_q rejects it.
  assign day_in = (7'(bus.day_tens) * 7'd10) + 7'(bus.day_ones);

  // One ROM serves both phases: the entered month during CHECK (range test)
  // and the running month index during ACCUM (length to add).
  assign rom_month = (state == ACCUM) ? idx_q : month_q;

  month_length_rom u_rom (
    .month (4'(rom_month)),
    .leap  (leap_q),
    .len   (len)
  );

  assign month_ok = (month_q != '0) && (month_q <= MONTH_W'(MONTH_DEC));
  assign check_ok = !digit_err_q && (day_q != 7'd0) && month_ok &&
                    (day_q <= 7'(len));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CHECK;
      CHECK:   state_nxt = check_ok ? ACCUM : DONE;
      ACCUM:   if (idx_q == month_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      month_q     <= '0;
      idx_q       <= '0;
      day_q       <= '0;
      digit_err_q <= 1'b0;
      acc_q       <= '0;
      doy_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // Stage: latch operands and clear the previous result
        IDLE: begin
          if (bus.start) begin
            month_q     <= bus.month;
            day_q       <= day_in;
            digit_err_q <= (bus.day_tens > BCD_MAX) || (bus.day_ones > BCD_MAX);
            valid_q     <= 1'b0;
            doy_q       <= '0;
          end
        end
        // Stage: range check; a rejected date leaves valid/doy cleared
        CHECK: begin
          if (check_ok) begin
            acc_q <= DOY_W'(day_q);
            idx_q <= MONTH_W'(1);
          end
        end
        // Stage: add one preceding month per clock
        ACCUM: begin
          if (idx_q == month_q) begin
            doy_q   <= acc_q;
            valid_q <= 1'b1;
          end else begin
            acc_q <= acc_q + DOY_W'(len);
            idx_q <= idx_q + MONTH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LEAP_YEAR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      leap_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      leap_q <= bus.leap_year;
    end
  end
`else
  assign leap_q = 1'b0;
`endif

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.valid       = valid_q;
  assign bus.day_of_year = doy_q;

endmodule

// File: tb/tb_day_of_year_calc.sv
// Testbench for day_of_year_calc: table of date vectors with expected results
// queued on start and compared on done, plus hand-written sequences for start
// during ACCUM and reset during ACCUM. Honours LEAP_YEAR_EN.
module tb_day_of_year_calc;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  day_of_year_calc_if #(.DOY_W(9), .MONTH_W(4)) bus ();

  day_of_year_calc #(.DOY_W(9), .MONTH_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] month;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       leap;
    logic       exp_valid;
    logic [8:0] exp_doy;
    int         exp_lat;
  } vec_t;

  typedef struct {
    logic       v;
    logic [8:0] doy;
    int         lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic add(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                     input logic l, input logic v, input logic [8:0] d, input int lat);
    vec_t x;
    x.month = m; x.tens = t; x.ones = o; x.leap = l;
    x.exp_valid = v; x.exp_doy = d; x.exp_lat = lat;
    vecs.push_back(x);
  endtask

  // Presents operands and pulses start across one rising edge (edge k).
  task automatic drive_start(input logic [3:0] m, input logic [3:0] t,
                             input logic [3:0] o, input logic l);
    @(negedge clk);
    bus.month    = m;
    bus.day_tens = t;
    bus.day_ones = o;
`ifdef LEAP_YEAR_EN
    bus.leap_year = l;
`else
    if (l) bus.start = 1'b0;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges after edge k until done is seen; bounded.
  task automatic wait_done(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic compare_result(input string name, input int lat, input logic ok);
    exp_t e;
    e = sb.pop_front();
    check($sformatf("%s_done_seen", name), 32'(ok), 32'd1);
    if (ok) begin
      check($sformatf("%s_valid", name), 32'(bus.valid), 32'(e.v));
      check($sformatf("%s_doy", name), 32'(bus.day_of_year), 32'(e.doy));
      check($sformatf("%s_latency", name), 32'(lat), 32'(e.lat));
      check($sformatf("%s_busy_in_done", name), 32'(bus.busy), 32'd1);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t x);
    exp_t e;
    int   lat;
    logic ok;
    string nm;
    nm = $sformatf("vec%0d_m%0d_d%0d%0d", idx, x.month, x.tens, x.ones);
    drive_start(x.month, x.tens, x.ones, x.leap);
    e.v = x.exp_valid; e.doy = x.exp_doy; e.lat = x.exp_lat;
    sb.push_back(e);
    check($sformatf("%s_busy_after_start", nm), 32'(bus.busy), 32'd1);
    wait_done(lat, ok);
    compare_result(nm, lat, ok);
    // One edge later: back in IDLE, result held.
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_done_single", nm), 32'(bus.done), 32'd0);
    check($sformatf("%s_busy_cleared", nm), 32'(bus.busy), 32'd0);
    check($sformatf("%s_valid_hold", nm), 32'(bus.valid), 32'(x.exp_valid));
    check($sformatf("%s_doy_hold", nm), 32'(bus.day_of_year), 32'(x.exp_doy));
  endtask

  initial begin
    int   lat;
    logic ok;
    int   pulses;
    exp_t e;

    bus.start    = 1'b0;
    bus.month    = '0;
    bus.day_tens = '0;
    bus.day_ones = '0;
`ifdef LEAP_YEAR_EN
    bus.leap_year = 1'b0;
`endif

    // month, tens, ones, leap, valid, doy, latency
    add(4'd1,  4'd0, 4'd1,  1'b0, 1'b1, 9'd1,   2);
    add(4'd4,  4'd1, 4'd5,  1'b0, 1'b1, 9'd105, 5);
    add(4'd12, 4'd3, 4'd1,  1'b0, 1'b1, 9'd365, 13);
    add(4'd2,  4'd3, 4'd0,  1'b0, 1'b0, 9'd0,   1);
    add(4'd1,  4'd0, 4'hA,  1'b0, 1'b0, 9'd0,   1);
    add(4'd1,  4'hA, 4'd0,  1'b0, 1'b0, 9'd0,   1);
    add(4'd13, 4'd0, 4'd1,  1'b0, 1'b0, 9'd0,   1);
    add(4'd0,  4'd0, 4'd1,  1'b0, 1'b0, 9'd0,   1);
    add(4'd4,  4'd0, 4'd0,  1'b0, 1'b0, 9'd0,   1);
    add(4'd4,  4'd3, 4'd1,  1'b0, 1'b0, 9'd0,   1);
    add(4'd2,  4'd2, 4'd8,  1'b0, 1'b1, 9'd59,  3);
    add(4'd7,  4'd3, 4'd1,  1'b0, 1'b1, 9'd212, 8);
    add(4'd3,  4'd0, 4'd1,  1'b0, 1'b1, 9'd60,  4);
    add(4'd2,  4'd2, 4'd9,  1'b0, 1'b0, 9'd0,   1);
`ifdef LEAP_YEAR_EN
    add(4'd3,  4'd0, 4'd1,  1'b1, 1'b1, 9'd61,  4);
    add(4'd2,  4'd2, 4'd9,  1'b1, 1'b1, 9'd60,  3);
    add(4'd12, 4'd3, 4'd1,  1'b1, 1'b1, 9'd366, 13);
    add(4'd1,  4'd3, 4'd1,  1'b1, 1'b1, 9'd31,  2);
`endif

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_doy", 32'(bus.day_of_year), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // start pulsed again mid-ACCUM must be ignored: June 10 -> 161, latency 7.
    drive_start(4'd6, 4'd1, 4'd0, 1'b0);
    e.v = 1'b1; e.doy = 9'd161; e.lat = 7;
    sb.push_back(e);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (lat == 3) begin
        bus.month = 4'd1; bus.day_tens = 4'd0; bus.day_ones = 4'd1;
        bus.start = 1'b1;
      end
      if (lat == 5) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    compare_result("restart_in_accum", lat, ok);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("restart_in_accum_no_second_done", 32'(pulses), 32'd0);
    check("restart_in_accum_doy_hold", 32'(bus.day_of_year), 32'd161);

    // reset during ACCUM: back to IDLE, outputs 0, no done.
    drive_start(4'd12, 4'd3, 4'd1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) pulses++;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_in_accum_busy", 32'(bus.busy), 32'd0);
    check("reset_in_accum_done", 32'(bus.done), 32'd0);
    check("reset_in_accum_valid", 32'(bus.valid), 32'd0);
    check("reset_in_accum_doy", 32'(bus.day_of_year), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("reset_in_accum_no_done", 32'(pulses), 32'd0);

    // Recovery after mid-operation reset.
    run_vec(99, vecs[1]);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
